// File: rtl/coeff_loader_pkg.sv
// Shared types for the coefficient loader: FSM state encoding and address layout.
package coeff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_e;

  localparam int DEFAULT_ADDRESS_WIDTH = 7;

  // The bank bit sits directly above the in-bank coefficient address.
  localparam int BANK_BIT_POS = DEFAULT_ADDRESS_WIDTH;

  function automatic int bank_bit(input int address_width);
    return address_width;
  endfunction

endpackage

// File: rtl/coeff_loader.sv
// Ping-pong coefficient store write controller: streams a full coefficient set into the
// shadow bank and swaps banks at a filter safe point. Optional framing check: COEFF_LOADER_LAST_CHECK_EN.
module coeff_loader
  import coeff_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 7,
  parameter int DATA_WIDTH    = 16,
  parameter int COEFF_COUNT   = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_last,
  input  logic                         swap_ok,
  output logic                         bank_sel,
  output logic                         we,
  output logic [ADDRESS_WIDTH:0]       waddr,
  output logic signed [DATA_WIDTH-1:0] wdata,
  output logic                         load_done,
  output logic                         load_err
);

  localparam int BANK_BIT = bank_bit(ADDRESS_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(COEFF_COUNT - 1);

  state_e                         state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]       cnt_q, cnt_d;
  logic                           bank_sel_q, bank_sel_d;
  logic                           we_q, we_d;
  logic [ADDRESS_WIDTH:0]         waddr_q, waddr_d;
  logic signed [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic                           accept;
  logic                           final_beat;

`ifndef COEFF_LOADER_LAST_CHECK_EN
  logic unused_last;
  assign unused_last = s_last;
`endif

  assign s_ready    = (state_q != WAIT_SWAP);
  assign accept     = s_valid && s_ready;
  assign final_beat = (cnt_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_sel_d = bank_sel_q;
    we_d       = accept;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (accept) begin
      waddr_d[BANK_BIT]          = ~bank_sel_q;
      waddr_d[ADDRESS_WIDTH-1:0] = cnt_q;
      wdata_d                    = s_data;
    end

    case (state_q)
      IDLE, LOAD: begin
        // IDLE holds cnt at 0, so both states share the per-beat progression.
        if (accept) begin
`ifdef COEFF_LOADER_LAST_CHECK_EN
          if (final_beat && s_last) begin
            state_d = WAIT_SWAP;
            cnt_d   = '0;
          end else if (final_beat || s_last) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = LOAD;
            cnt_d   = cnt_q + ADDRESS_WIDTH'(1);
          end
`else
          if (final_beat) begin
            state_d = WAIT_SWAP;
            cnt_d   = '0;
          end else begin
            state_d = LOAD;
            cnt_d   = cnt_q + ADDRESS_WIDTH'(1);
          end
`endif
        end
      end
      WAIT_SWAP: begin
        if (swap_ok) begin
          bank_sel_d = ~bank_sel_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bank_sel_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_sel_q <= bank_sel_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bank_sel  = bank_sel_q;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign load_done = done_q;
`ifdef COEFF_LOADER_LAST_CHECK_EN
  assign load_err  = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
  assign load_err   = 1'b0;
`endif

endmodule
